// File: rtl/xadc_drp_responder_if.sv
// AXI-Stream style sample channel used to feed stimulus values into the
// DRP responder. Only tdata/tvalid/tready carry meaning for the sink.
interface axis_interface #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tid;
    logic                    tuser;
    logic                    tdest;

    modport Source (
        output tdata, tvalid, tlast, tkeep, tid, tuser, tdest,
        input  tready
    );

    modport Sink (
        input  tdata, tvalid, tlast, tkeep, tid, tuser, tdest,
        output tready
    );
endinterface

// File: rtl/xadc_drp_responder.sv
// Behavioural stand-in for an XADC DRP port: two stimulus channels are
// latched into pending registers, published to visible registers once per
// conversion sequence (with an xadc_eos pulse), and served over DRP reads
// with a fixed drdy latency.
module xadc_drp_responder #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 7,
    parameter logic [ADDR_WIDTH-1:0] VOLTAGE_ADDR = 7'h03,
    parameter logic [ADDR_WIDTH-1:0] CURRENT_ADDR = 7'h1B,
    parameter int                    EOS_PERIOD   = 64,
    parameter int                    DRDY_LATENCY = 4
) (
    input  logic                  xadc_dclk,
    input  logic                  xadc_reset_n,
    input  logic [ADDR_WIDTH-1:0] xadc_daddr,
    input  logic                  xadc_den,
    input  logic                  xadc_dwe,
    input  logic [DATA_WIDTH-1:0] xadc_di,
    output logic                  xadc_drdy,
    output logic [DATA_WIDTH-1:0] xadc_do,
    output logic                  xadc_eos,
    output logic                  drp_protocol_error,
    axis_interface.Sink           voltage_samples,
    axis_interface.Sink           current_samples
);

    localparam int              SEQ_W    = $clog2(EOS_PERIOD);
    localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(EOS_PERIOD - 1);
    localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);
    localparam logic [3:0]       LAT_LOAD = 4'(DRDY_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } drp_state_e;

    // Synchronised internal reset: asserts with xadc_reset_n, releases two edges later.
    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    // Sample path state.
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic                  eos_q, eos_d;
    logic [DATA_WIDTH-1:0] v_pend_q, v_pend_d, v_vis_q, v_vis_d;
    logic [DATA_WIDTH-1:0] c_pend_q, c_pend_d, c_vis_q, c_vis_d;
    logic                  copy_now;

    // DRP state.
    drp_state_e            state_q;
    logic [3:0]            lat_cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] do_q;
    logic                  drdy_q;
    logic                  perr_q;
    logic [DATA_WIDTH-1:0] rd_value;

    // Sideband fields of the sample channels carry no meaning here.
    logic unused_sideband;
    assign unused_sideband = ^{xadc_di,
                               voltage_samples.tlast, voltage_samples.tkeep,
                               voltage_samples.tid, voltage_samples.tuser,
                               voltage_samples.tdest,
                               current_samples.tlast, current_samples.tkeep,
                               current_samples.tid, current_samples.tuser,
                               current_samples.tdest};

    // Two-flop reset synchroniser: async assert, sync release.
    always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
        if (!xadc_reset_n) rst_sync_q <= 2'b00;
        else               rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_sync_n = rst_sync_q[1];

    assign voltage_samples.tready = rst_sync_n;
    assign current_samples.tready = rst_sync_n;

    // Sequence counter, EOS pulse and pending/visible register updates.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
        seq_d    = seq_q + SEQ_ONE;
        v_pend_d = v_pend_q;
        c_pend_d = c_pend_q;
        v_vis_d  = v_vis_q;
        c_vis_d  = c_vis_q;
        copy_now = (seq_q == SEQ_LAST);
        eos_d    = copy_now;
        if (copy_now) begin
            seq_d   = '0;
            v_vis_d = v_pend_q;   // old pending value; a same-cycle beat waits for the next sequence
            c_vis_d = c_pend_q;
        end
        if (voltage_samples.tvalid && rst_sync_n) v_pend_d = voltage_samples.tdata;
        if (current_samples.tvalid && rst_sync_n) c_pend_d = current_samples.tdata;
    end

    // Register the sample path.
    always_ff @(posedge xadc_dclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            seq_q    <= '0;
            eos_q    <= 1'b0;
            v_pend_q <= '0;
            c_pend_q <= '0;
            v_vis_q  <= '0;
            c_vis_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            seq_q    <= seq_d;
            eos_q    <= eos_d;
            v_pend_q <= v_pend_d;
            c_pend_q <= c_pend_d;
            v_vis_q  <= v_vis_d;
            c_vis_q  <= c_vis_d;
        end
    end

    // Read-data mux over the visible registers (pre-copy values this cycle).
    always_comb begin
        rd_value = '0;
        if (xadc_daddr == VOLTAGE_ADDR)      rd_value = v_vis_q;
        else if (xadc_daddr == CURRENT_ADDR) rd_value = c_vis_q;
    end

    // DRP FSM with registered drdy/do and sticky protocol-error flag.
    always_ff @(posedge xadc_dclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            rdata_q   <= '0;
            do_q      <= '0;
            drdy_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            if (xadc_den && (state_q != IDLE)) perr_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (xadc_den) begin
                        rdata_q <= xadc_dwe ? '0 : rd_value;
                        if (LAT_LOAD == 4'd0) begin
                            state_q <= RESPOND;
                            drdy_q  <= 1'b1;
                            do_q    <= xadc_dwe ? '0 : rd_value;
                        end else begin
                            state_q   <= BUSY;
                            lat_cnt_q <= LAT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (lat_cnt_q == 4'd1) begin
                        state_q <= RESPOND;
                        drdy_q  <= 1'b1;
                        do_q    <= rdata_q;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                    drdy_q  <= 1'b0;
                    do_q    <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    drdy_q  <= 1'b0;
                    do_q    <= '0;
                end
            endcase
        end
    end

    assign xadc_drdy          = drdy_q;
    assign xadc_do            = do_q;
    assign xadc_eos           = eos_q;
    assign drp_protocol_error = perr_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Directed bench for xadc_drp_responder with EOS_PERIOD=16, DRDY_LATENCY=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_xadc_drp_responder;

    localparam int EOS_P = 16;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  daddr = '0;
    logic        den = 1'b0;
    logic        dwe = 1'b0;
    logic [15:0] di = '0;
    logic        drdy;
    logic [15:0] dout;
    logic        eos;
    logic        perr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;   // posedges since synchronised release; cyc % 16 is the DUT sequence count

    axis_interface #(.DATA_WIDTH(16)) v_if ();
    axis_interface #(.DATA_WIDTH(16)) c_if ();

    xadc_drp_responder #(
        .EOS_PERIOD  (EOS_P),
        .DRDY_LATENCY(LAT)
    ) dut (
        .xadc_dclk         (clk),
        .xadc_reset_n      (rst_n),
        .xadc_daddr        (daddr),
        .xadc_den          (den),
        .xadc_dwe          (dwe),
        .xadc_di           (di),
        .xadc_drdy         (drdy),
        .xadc_do           (dout),
        .xadc_eos          (eos),
        .drp_protocol_error(perr),
        .voltage_samples   (v_if),
        .current_samples   (c_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_phase(input int p);
        while ((cyc % EOS_P) != p) tick();
    endtask

    task automatic beat(input logic is_current, input logic [15:0] d);
        if (is_current) begin c_if.tdata = d; c_if.tvalid = 1'b1; end
        else            begin v_if.tdata = d; v_if.tvalid = 1'b1; end
        tick();
        v_if.tvalid = 1'b0;
        c_if.tvalid = 1'b0;
    endtask

    // One DRP transaction: den for one cycle, drdy expected exactly LAT cycles later.
    task automatic drp_txn(input string tag, input logic [6:0] a, input logic we,
                           input logic [15:0] wdata, input logic [15:0] exp);
        daddr = a; dwe = we; di = wdata; den = 1'b1;
        tick();
        den = 1'b0; dwe = 1'b0; di = '0;
        for (int i = 1; i < LAT; i++) begin
            check({tag, " drdy early"}, {15'd0, drdy}, 16'd0);
            tick();
        end
        check({tag, " drdy"}, {15'd0, drdy}, 16'd1);
        check({tag, " do"}, dout, exp);
        tick();
        check({tag, " drdy end"}, {15'd0, drdy}, 16'd0);
        check({tag, " do idle"}, dout, 16'd0);
    endtask

    // Release reset, pass the two synchroniser edges, and check the first EOS
    // lands in cycle 17 with no drdy appearing.
    task automatic release_and_check_eos(input string tag);
        rst_n = 1'b1;
        tick();
        tick();
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            check({tag, " eos timing"}, {15'd0, eos}, (i == 17) ? 16'd1 : 16'd0);
            check({tag, " no drdy"}, {15'd0, drdy}, 16'd0);
            tick();
        end
    endtask

    initial begin
        int pulses;
        v_if.tdata = '0; v_if.tvalid = 1'b0; v_if.tlast = 1'b0; v_if.tkeep = '1;
        v_if.tid = 1'b0; v_if.tuser = 1'b0; v_if.tdest = 1'b0;
        c_if.tdata = '0; c_if.tvalid = 1'b0; c_if.tlast = 1'b0; c_if.tkeep = '1;
        c_if.tid = 1'b0; c_if.tuser = 1'b0; c_if.tdest = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst drdy", {15'd0, drdy}, 16'd0);
        check("rst do", dout, 16'd0);
        check("rst eos", {15'd0, eos}, 16'd0);
        check("rst perr", {15'd0, perr}, 16'd0);
        check("rst v tready", {15'd0, v_if.tready}, 16'd0);
        check("rst c tready", {15'd0, c_if.tready}, 16'd0);

        // Release and confirm first EOS position (cycle counter ends at 20).
        release_and_check_eos("init");
        check("v tready", {15'd0, v_if.tready}, 16'd1);
        check("c tready", {15'd0, c_if.tready}, 16'd1);
        wait_phase(2);

        // Beats before the next EOS stay invisible.
        beat(1'b0, 16'h1230);
        beat(1'b1, 16'hABC0);
        drp_txn("cur before eos", 7'h1B, 1'b0, 16'h0, 16'h0000);
        drp_txn("volt before eos", 7'h03, 1'b0, 16'h0, 16'h0000);

        // EOS is a single-cycle pulse in the cycle after count 15.
        wait_phase(15);
        check("eos before", {15'd0, eos}, 16'd0);
        tick();
        check("eos pulse", {15'd0, eos}, 16'd1);
        tick();
        check("eos after", {15'd0, eos}, 16'd0);

        drp_txn("volt after eos", 7'h03, 1'b0, 16'h0, 16'h1230);
        drp_txn("cur after eos", 7'h1B, 1'b0, 16'h0, 16'hABC0);

        // Beat in the copy cycle goes to the following sequence.
        wait_phase(15);
        beat(1'b0, 16'h5550);
        drp_txn("copy-cycle beat old", 7'h03, 1'b0, 16'h0, 16'h1230);
        wait_phase(15);
        tick();
        drp_txn("copy-cycle beat new", 7'h03, 1'b0, 16'h0, 16'h5550);

        // den in the copy cycle captures the pre-copy visible value.
        beat(1'b0, 16'h7770);
        wait_phase(15);
        drp_txn("den in copy cycle", 7'h03, 1'b0, 16'h0, 16'h5550);
        drp_txn("after copy", 7'h03, 1'b0, 16'h0, 16'h7770);

        // den during BUSY cycle 2: ignored, one drdy only, sticky error.
        daddr = 7'h03; dwe = 1'b0; den = 1'b1;
        tick();
        den = 1'b0;
        tick();
        check("perr before", {15'd0, perr}, 16'd0);
        den = 1'b1;
        tick();
        den = 1'b0;
        check("busy den drdy early", {15'd0, drdy}, 16'd0);
        check("perr set", {15'd0, perr}, 16'd1);
        tick();
        check("busy den drdy", {15'd0, drdy}, 16'd1);
        check("busy den do", dout, 16'h7770);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (drdy) pulses++;
        end
        check("single drdy", 16'(pulses), 16'd0);
        check("perr sticky", {15'd0, perr}, 16'd1);

        // Unmapped read and write acknowledge.
        drp_txn("unmapped read", 7'h10, 1'b0, 16'h0, 16'h0000);
        drp_txn("write ack", 7'h03, 1'b1, 16'hFFFF, 16'h0000);
        drp_txn("volt after write", 7'h03, 1'b0, 16'h0, 16'h7770);
        wait_phase(15);
        tick();
        drp_txn("volt next seq", 7'h03, 1'b0, 16'h0, 16'h7770);
        drp_txn("cur next seq", 7'h1B, 1'b0, 16'h0, 16'hABC0);

        // Reset in BUSY cycle 2 aborts the transaction.
        daddr = 7'h03; den = 1'b1;
        tick();
        den = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("async rst drdy", {15'd0, drdy}, 16'd0);
        check("async rst do", dout, 16'd0);
        check("async rst perr", {15'd0, perr}, 16'd0);
        check("async rst eos", {15'd0, eos}, 16'd0);
        check("async rst tready", {15'd0, v_if.tready}, 16'd0);
        tick();
        tick();
        check("held rst drdy", {15'd0, drdy}, 16'd0);
        release_and_check_eos("mid-txn rst");
        drp_txn("volt cleared", 7'h03, 1'b0, 16'h0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
